tcb_arbiter: RTL

Round-robin arbiter sharing one TCB subordinate, such as a GPIO or UART controller, between `MN` TCB managers. It sits between several CPU/DMA manager ports and a single peripheral port. It forwards one transfer per cycle with zero added request latency. It routes each delayed read/error response back to the manager that issued the transfer.

---
 rtl/tcb_arbiter_pkg.sv | 22 ++
 rtl/tcb_arbiter_rr.sv | 47 ++++
 rtl/tcb_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/tcb_arbiter_pkg.sv
// tcb_arbiter_pkg
//   Shared types and helpers for the TCB round-robin arbiter.
//   - clog2_min1 : index width for a manager count (never below 1 bit)
//   - idx_t      : manager index wide enough for the largest supported MN
//   - rsp_ent_t  : one response-routing pipeline entry {vld, idx}
package tcb_arbiter_pkg;

  localparam int MN_MAX    = 16;
  localparam int IDX_MAX_W = 4;

  typedef logic [IDX_MAX_W-1:0] idx_t;

  typedef struct packed {
    logic vld;
    idx_t idx;
  } rsp_ent_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tcb_arbiter_rr.sv
// tcb_arbiter_rr
//   Combinational rotate-priority encoder. The grant goes to the first set
//   request at or after ptr (modulo MN); while lck is set the grant is pinned
//   to lck_idx regardless of the other requests.
// Ports:
//   req[MN]      request vector
//   ptr          highest-priority index
//   lck, lck_idx lock override
//   gnt_vld      a grant is active
//   gnt_idx      granted index
module tcb_arbiter_rr
  import tcb_arbiter_pkg::*;
#(
  parameter int MN = 2,
  parameter int IW = clog2_min1(MN)
)(
  input  logic [MN-1:0] req,
  input  logic [IW-1:0] ptr,
  input  logic          lck,
  input  logic [IW-1:0] lck_idx,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx
);

  localparam logic [IW:0] MN_V = (IW+1)'(MN);

  logic [2*MN-1:0] req_dbl;
  logic [MN-1:0]   req_rot;
  logic [IW-1:0]   off;
  logic [IW:0]     sum;

  always_comb begin
    // Rotate so that bit 0 is the request at ptr; the lowest set bit of the
    // rotated vector is the offset of the winner from ptr.
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[MN-1:0];
    off = '0;
    for (int k = MN-1; k >= 0; k--) begin
      if (req_rot[k]) off = IW'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= MN_V) sum = sum - MN_V;
    gnt_vld = lck ? req[lck_idx] : |req;
    gnt_idx = lck ? lck_idx : sum[IW-1:0];
  end

endmodule

// File: rtl/tcb_arbiter.sv
// tcb_arbiter
//   Round-robin arbiter sharing one TCB subordinate among MN managers.
//   Requests are forwarded combinationally; responses are routed back to the
//   issuing manager DLY cycles after its transfer.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   sub_vld/wen/ben/adr/wdt [MN]      manager-side request inputs
//   sub_rdy/rdt/err [MN]              manager-side handshake/response outputs
//   man_vld/wen/ben/adr/wdt           subordinate-side request outputs
//   man_rdy/rdt/err                   subordinate-side handshake/response inputs
module tcb_arbiter
  import tcb_arbiter_pkg::*;
#(
  parameter int MN  = 2,
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int DLY = 1
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                sub_vld [MN],
  input  logic                sub_wen [MN],
  input  logic [DW/8-1:0]     sub_ben [MN],
  input  logic [AW-1:0]       sub_adr [MN],
  input  logic [DW-1:0]       sub_wdt [MN],
  output logic                sub_rdy [MN],
  output logic [DW-1:0]       sub_rdt [MN],
  output logic                sub_err [MN],
  output logic                man_vld,
  output logic                man_wen,
  output logic [DW/8-1:0]     man_ben,
  output logic [AW-1:0]       man_adr,
  output logic [DW-1:0]       man_wdt,
  input  logic                man_rdy,
  input  logic [DW-1:0]       man_rdt,
  input  logic                man_err
);

  localparam int IW = clog2_min1(MN);

  logic [MN-1:0] req;
  logic [IW-1:0] ptr;
  logic          lck;
  logic [IW-1:0] lck_idx;
  logic          gnt_vld;
  logic [IW-1:0] gnt_idx;
  logic          trn;
  rsp_ent_t      pipe [DLY];
  rsp_ent_t      rsp;

  always_comb begin
    for (int i = 0; i < MN; i++) req[i] = sub_vld[i];
  end

  tcb_arbiter_rr #(.MN(MN), .IW(IW)) u_rr (
    .req     (req),
    .ptr     (ptr),
    .lck     (lck),
    .lck_idx (lck_idx),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  assign trn = gnt_vld & man_rdy;
  assign rsp = pipe[DLY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      lck     <= 1'b0;
      lck_idx <= '0;
      for (int s = 0; s < DLY; s++) pipe[s] <= '0;
    end else begin
      if (trn) ptr <= (gnt_idx == IW'(MN-1)) ? '0 : gnt_idx + 1'b1;
      // A stalled grant keeps ownership until its transfer completes.
      if (gnt_vld && !man_rdy) begin
        lck     <= 1'b1;
        lck_idx <= gnt_idx;
      end else if (trn) begin
        lck <= 1'b0;
      end
      pipe[0] <= '{vld: trn, idx: idx_t'(gnt_idx)};
      for (int s = 1; s < DLY; s++) pipe[s] <= pipe[s-1];
    end
  end

  always_comb begin
    man_vld = 1'b0;
    man_wen = 1'b0;
    man_ben = '0;
    man_adr = '0;
    man_wdt = '0;
    for (int i = 0; i < MN; i++) begin
      sub_rdy[i] = 1'b0;
      if (gnt_vld && gnt_idx == IW'(i)) begin
        man_vld    = sub_vld[i];
        man_wen    = sub_wen[i];
        man_ben    = sub_ben[i];
        man_adr    = sub_adr[i];
        man_wdt    = sub_wdt[i];
        sub_rdy[i] = man_rdy;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < MN; i++) begin
      sub_rdt[i] = '0;
      sub_err[i] = 1'b0;
      if (rsp.vld && rsp.idx == idx_t'(i)) begin
        sub_rdt[i] = man_rdt;
        sub_err[i] = man_err;
      end
    end
  end

endmodule
